// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU memory stage owns the port by default,
// a device requester gets single address slots when the CPU is idle or after a bounded wait.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wren,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dev_req,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  input  logic              dev_wren,
  output logic              dev_ack,
  output logic [DATA_W-1:0] dev_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [1:0]        arb_state
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEV_ADDR = 2'd1,
    DEV_DATA = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] wait_q;
  logic [CNT_W-1:0] wait_d;
  logic             dev_sel;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE, DEV_DATA: begin
        if (!dev_req) begin
          state_d = IDLE;
          wait_d  = '0;
        end else if (!cpu_req) begin
          state_d = DEV_ADDR;
          wait_d  = '0;
        end else if (wait_q == LAST) begin
          // device starved long enough: steal one slot from the CPU
          state_d = DEV_ADDR;
          wait_d  = '0;
        end else begin
          state_d = IDLE;
          wait_d  = wait_q + CNT_W'(1);
        end
      end
      DEV_ADDR: begin
        state_d = DEV_DATA;
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

  assign dev_sel = (state_q == DEV_ADDR);

  assign mem_addr  = dev_sel ? dev_addr  : cpu_addr;
  assign mem_wdata = dev_sel ? dev_wdata : cpu_wdata;
  // write strobe is forced low while reset is held, even mid-cycle
  assign mem_wren  = reset &
                     (dev_sel ? dev_wren : (cpu_req & cpu_wren));

  assign cpu_stall = dev_sel & cpu_req;
  assign dev_ack   = (state_q == DEV_DATA);
  assign cpu_rdata = mem_q;
  assign dev_rdata = mem_q;
  assign arb_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at MAX_WAIT=4 with a
// memory model, one at MAX_WAIT=1 sharing the same stimulus.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_wren = 1'b0;
  logic        dev_req = 1'b0;
  logic [31:0] dev_addr = '0;
  logic [31:0] dev_wdata = '0;
  logic        dev_wren = 1'b0;

  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dev_ack;
  logic [31:0] dev_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic [1:0]  arb_state;

  logic [31:0] b_cpu_rdata;
  logic        b_cpu_stall;
  logic        b_dev_ack;
  logic [31:0] b_dev_rdata;
  logic [31:0] b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic        b_mem_wren;
  logic [31:0] b_mem_q;
  logic [1:0]  b_arb_state;

  logic [31:0] mem [0:255];
  logic [1:0]  seq4 [0:5];
  int checks = 0;
  int errors = 0;
  int acks = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) mem[mem_addr[7:0]] <= mem_wdata;
    mem_q <= mem[mem_addr[7:0]];
  end

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) u_a (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wren(cpu_wren), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dev_req(dev_req), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_wren(dev_wren), .dev_ack(dev_ack), .dev_rdata(dev_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_q(mem_q), .arb_state(arb_state)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(1)) u_b (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wren(cpu_wren), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .dev_req(dev_req), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_wren(dev_wren), .dev_ack(b_dev_ack), .dev_rdata(b_dev_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wren(b_mem_wren),
    .mem_q(b_mem_q), .arb_state(b_arb_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  initial begin
    b_mem_q = '0;
    seq4[0] = 2'd0; seq4[1] = 2'd1; seq4[2] = 2'd2;
    seq4[3] = 2'd1; seq4[4] = 2'd2; seq4[5] = 2'd0;

    // reset held with live requests on both sides
    cpu_req = 1'b1; cpu_wren = 1'b1;
    cpu_addr = 32'h10; cpu_wdata = 32'hCAFE;
    dev_req = 1'b1;
    nxt(); nxt(); #1;
    chk("rst_state", 32'(arb_state), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_ack", 32'(dev_ack), 32'd0);

    // test 1: CPU only
    nxt();
    reset = 1'b1; dev_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t1_state", 32'(arb_state), 32'd0);
      chk("t1_wren", 32'(mem_wren), 32'd1);
      chk("t1_addr", mem_addr, 32'h10);
      chk("t1_stall", 32'(cpu_stall), 32'd0);
      nxt();
    end

    // preload 0x40 through the CPU, then read back 0x10
    cpu_addr = 32'h40; cpu_wdata = 32'h1234;
    #1;
    chk("pre_wren", 32'(mem_wren), 32'd1);
    nxt();
    cpu_addr = 32'h10; cpu_wren = 1'b0;
    nxt();

    // test 2: device only, single-cycle request
    cpu_req = 1'b0;
    dev_req = 1'b1; dev_addr = 32'h40; dev_wren = 1'b0;
    #1;
    chk("t1_rdata", cpu_rdata, 32'hCAFE);
    chk("t2_idle", 32'(arb_state), 32'd0);
    nxt();
    dev_req = 1'b0;
    #1;
    chk("t2_daddr", 32'(arb_state), 32'd1);
    chk("t2_maddr", mem_addr, 32'h40);
    chk("t2_nowr", 32'(mem_wren), 32'd0);
    chk("t2_stall", 32'(cpu_stall), 32'd0);
    nxt(); #1;
    chk("t2_ddata", 32'(arb_state), 32'd2);
    chk("t2_ack", 32'(dev_ack), 32'd1);
    chk("t2_rdata", dev_rdata, 32'h1234);
    nxt(); #1;
    chk("t2_back", 32'(arb_state), 32'd0);
    chk("t2_ackoff", 32'(dev_ack), 32'd0);

    // test 3 + test 6: contention with continuous CPU traffic
    nxt();
    cpu_req = 1'b1; cpu_addr = 32'h20; cpu_wren = 1'b0;
    dev_req = 1'b1; dev_addr = 32'h44;
    dev_wren = 1'b1; dev_wdata = 32'h5555;
    #1;
    chk("t3_c0", 32'(arb_state), 32'd0);
    chk("t6_c0", 32'(b_arb_state), 32'd0);
    nxt(); #1;
    chk("t3_c1", 32'(arb_state), 32'd0);
    chk("t3_c1_stall", 32'(cpu_stall), 32'd0);
    chk("t6_c1", 32'(b_arb_state), 32'd1);
    chk("t6_c1_stall", 32'(b_cpu_stall), 32'd1);
    nxt(); #1;
    chk("t3_c2", 32'(arb_state), 32'd0);
    chk("t6_c2", 32'(b_arb_state), 32'd2);
    chk("t6_c2_ack", 32'(b_dev_ack), 32'd1);
    chk("t6_c2_stall", 32'(b_cpu_stall), 32'd0);
    nxt(); #1;
    chk("t3_c3", 32'(arb_state), 32'd0);
    chk("t3_c3_stall", 32'(cpu_stall), 32'd0);
    chk("t6_c3", 32'(b_arb_state), 32'd1);
    nxt(); #1;
    chk("t3_c4", 32'(arb_state), 32'd1);
    chk("t3_c4_stall", 32'(cpu_stall), 32'd1);
    chk("t3_c4_addr", mem_addr, 32'h44);
    chk("t3_c4_wren", 32'(mem_wren), 32'd1);
    nxt();
    dev_req = 1'b0; dev_wren = 1'b0;
    #1;
    chk("t3_c5", 32'(arb_state), 32'd2);
    chk("t3_c5_ack", 32'(dev_ack), 32'd1);
    chk("t3_c5_stall", 32'(cpu_stall), 32'd0);
    chk("t3_c5_addr", mem_addr, 32'h20);
    nxt();
    cpu_req = 1'b0;
    #1;
    chk("t3_c6", 32'(arb_state), 32'd0);
    chk("t3_devwr", mem[8'h44], 32'h5555);

    // test 4: back-to-back device accesses
    nxt();
    dev_req = 1'b1; dev_addr = 32'h40; dev_wren = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) dev_req = 1'b0;
      #1;
      chk("t4_seq", 32'(arb_state), 32'(seq4[i]));
      acks += int'(dev_ack);
      nxt();
    end
    chk("t4_acks", acks, 32'd2);

    // test 5: reset during DEV_ADDR
    dev_req = 1'b1; dev_addr = 32'h48;
    dev_wren = 1'b1; dev_wdata = 32'h77;
    #1;
    chk("t5_idle", 32'(arb_state), 32'd0);
    nxt(); #1;
    chk("t5_daddr", 32'(arb_state), 32'd1);
    chk("t5_wren", 32'(mem_wren), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_rst_state", 32'(arb_state), 32'd0);
    chk("t5_rst_wren", 32'(mem_wren), 32'd0);
    chk("t5_rst_ack", 32'(dev_ack), 32'd0);
    nxt(); #1;
    chk("t5_hold_ack", 32'(dev_ack), 32'd0);
    chk("t5_hold_state", 32'(arb_state), 32'd0);
    reset = 1'b1;
    nxt();
    dev_req = 1'b0;
    #1;
    chk("t5_regrant", 32'(arb_state), 32'd1);
    nxt();
    dev_wren = 1'b0;
    #1;
    chk("t5_ddata", 32'(arb_state), 32'd2);
    chk("t5_ack", 32'(dev_ack), 32'd1);
    chk("t5_devwr", mem[8'h48], 32'h77);
    nxt(); #1;
    chk("t5_end", 32'(arb_state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
